// File: rtl/lcd_sprite_fetch_pkg.sv
// rtl/lcd_sprite_fetch_pkg.sv - shared state encoding and buffer depth for the sprite fetch sequencer
package lcd_sprite_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    localparam int FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/lcd_sprite_fetch_if.sv
// rtl/lcd_sprite_fetch_if.sv - request, ROM and pixel-stream signals of the sprite fetch sequencer
interface lcd_sprite_fetch_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COORD_WIDTH = 11
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COORD_WIDTH-1:0] spr_w;
    logic [COORD_WIDTH-1:0] spr_h;
    logic [COORD_WIDTH-1:0] org_x;
    logic [COORD_WIDTH-1:0] org_y;
    logic                   busy;
    logic                   done;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic                   rom_rd;
    logic [DATA_WIDTH-1:0]  rom_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [DATA_WIDTH-1:0]  pix_data;
    logic [COORD_WIDTH-1:0] pix_x;
    logic [COORD_WIDTH-1:0] pix_y;
    logic                   pix_last;

    modport master (
        output start, base_addr, spr_w, spr_h, org_x, org_y, rom_data, pix_ready,
        input  busy, done, rom_addr, rom_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );

    modport slave (
        input  start, base_addr, spr_w, spr_h, org_x, org_y, rom_data, pix_ready,
        output busy, done, rom_addr, rom_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
endinterface

// File: rtl/lcd_sprite_fetch_buf2.sv
// rtl/lcd_sprite_fetch_buf2.sv - 2-entry synchronous FIFO holding {last, y, x, data} pixel entries
module lcd_sprite_fetch_buf2
    import lcd_sprite_fetch_pkg::*;
#(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);
    logic [WIDTH-1:0] r_mem [FETCH_BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The upstream credit rule guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (rstn) assert (!(i_push && r_count == 2'(FETCH_BUF_DEPTH) && !i_pop));
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/lcd_sprite_fetch.sv
// rtl/lcd_sprite_fetch.sv - walks a row-major sprite in ROM and emits a coordinate-tagged pixel stream
module lcd_sprite_fetch
    import lcd_sprite_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COORD_WIDTH = 11
) (
    input logic               clk,
    input logic               rstn,
    lcd_sprite_fetch_if.slave bus
);
    localparam int ENTRY_W = 1 + 2 * COORD_WIDTH + DATA_WIDTH;

    fetch_state_t           r_state;
    fetch_state_t           w_next;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [COORD_WIDTH-1:0] r_col, r_row, r_w, r_h, r_ox, r_oy;
    logic [COORD_WIDTH-1:0] r_tag_x, r_tag_y;
    logic                   r_tag_last;
    logic                   r_inflight;
    logic [1:0]             w_cnt;
    logic [ENTRY_W-1:0]     w_head;
    logic                   w_pop, w_credit, w_issue, w_last_pix, w_zero;
    logic                   w_busy, w_done, w_valid;

    assign w_valid    = (w_cnt != 2'd0);
    assign w_pop      = w_valid && bus.pix_ready;
    // Buffered + in-flight entries, less the one leaving now, must leave room for one more.
    assign w_credit   = (({1'b0, w_cnt} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
    assign w_last_pix = (r_col == r_w - COORD_WIDTH'(1)) && (r_row == r_h - COORD_WIDTH'(1));
    assign w_zero     = (bus.spr_w == '0) || (bus.spr_h == '0);

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = w_zero ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                w_busy  = 1'b1;
                w_issue = w_credit;
                if (w_issue && w_last_pix) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_cnt == 2'd0 && !r_inflight) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_tag_x    <= '0;
            r_tag_y    <= '0;
            r_tag_last <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (r_state == ST_IDLE && bus.start && !w_zero) begin
                r_addr <= bus.base_addr;
                r_w    <= bus.spr_w;
                r_h    <= bus.spr_h;
                r_ox   <= bus.org_x;
                r_oy   <= bus.org_y;
                r_col  <= '0;
                r_row  <= '0;
            end
            if (w_issue) begin
                r_tag_x    <= r_ox + r_col;
                r_tag_y    <= r_oy + r_row;
                r_tag_last <= w_last_pix;
                r_addr     <= r_addr + ADDR_WIDTH'(1);
                if (r_col == r_w - COORD_WIDTH'(1)) begin
                    r_col <= '0;
                    r_row <= r_row + COORD_WIDTH'(1);
                end else begin
                    r_col <= r_col + COORD_WIDTH'(1);
                end
            end
        end
    end

    lcd_sprite_fetch_buf2 #(.WIDTH(ENTRY_W)) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_inflight),
        .i_data  ({r_tag_last, r_tag_y, r_tag_x, bus.rom_data}),
        .i_pop   (w_pop),
        .o_count (w_cnt),
        .o_head  (w_head)
    );

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rom_addr  = r_addr;
    assign bus.rom_rd    = w_issue;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_head[DATA_WIDTH-1:0];
    assign bus.pix_x     = w_head[DATA_WIDTH +: COORD_WIDTH];
    assign bus.pix_y     = w_head[DATA_WIDTH+COORD_WIDTH +: COORD_WIDTH];
    assign bus.pix_last  = w_valid && w_head[ENTRY_W-1];
endmodule

// File: tb/tb_lcd_sprite_fetch.sv
// tb/tb_lcd_sprite_fetch.sv - table-driven and randomized checks of lcd_sprite_fetch against a sprite model
module tb_lcd_sprite_fetch;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lcd_sprite_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .COORD_WIDTH(11)) bus ();

    lcd_sprite_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .COORD_WIDTH(11)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        last;
    } pix_t;

    typedef struct {
        logic [7:0] base;
        int w; int h; int ox; int oy;
        int mode;
        bit mid;
        int exp_n; int exp_lx; int exp_ly;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return (cyc % 4 == 1) || (cyc % 4 == 0);
    endfunction

    task automatic run_case(input int id, input vec_t v);
        pix_t exp_q[$];
        pix_t got_q[$];
        logic [7:0] exp_a[$];
        logic [7:0] got_a[$];
        bit busy_log[$];
        pix_t p, cur_p, prev_p;
        bit prev_stall = 0;
        int done_cnt = 0, done_cyc = -1, first_rd = -1, first_valid = -1;
        int n_valid = 0, stab_err = 0, seq_err = 0, addr_err = 0, busy_err = 0;
        bit exp_busy;

        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                exp_a.push_back(8'(int'(v.base) + r * v.w + c));
                p.d    = rom[8'(int'(v.base) + r * v.w + c)];
                p.x    = 11'(v.ox + c);
                p.y    = 11'(v.oy + r);
                p.last = (r == v.h - 1) && (c == v.w - 1);
                exp_q.push_back(p);
            end
        end

        @(negedge clk);
        bus.base_addr = v.base;
        bus.spr_w     = 11'(v.w);
        bus.spr_h     = 11'(v.h);
        bus.org_x     = 11'(v.ox);
        bus.org_y     = 11'(v.oy);
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus.start = v.mid && (cyc == 3);
            if (v.mid && cyc == 3) begin
                bus.base_addr = 8'h00;
                bus.spr_w     = 11'd9;
                bus.spr_h     = 11'd9;
                bus.org_x     = 11'd0;
                bus.org_y     = 11'd0;
            end
            bus.pix_ready = ready_for(v.mode, cyc);
            #1;
            cur_p = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last};
            if (prev_stall && (!bus.pix_valid || cur_p !== prev_p)) stab_err++;
            if (bus.pix_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
                if (bus.pix_ready) got_q.push_back(cur_p);
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_p     = cur_p;
            if (bus.rom_rd) begin
                got_a.push_back(bus.rom_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            busy_log.push_back(bus.busy);
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        bus.start = 1'b0;

        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) seq_err++;
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            if (got_a[i] !== exp_a[i]) addr_err++;
        for (int i = 0; i < busy_log.size(); i++) begin
            exp_busy = (exp_q.size() != 0) && (done_cyc > 0) && (i + 1 < done_cyc);
            if (busy_log[i] !== exp_busy) busy_err++;
        end

        check($sformatf("v%0d_pix_count", id), got_q.size(), exp_q.size());
        check($sformatf("v%0d_pix_seq", id), seq_err, 0);
        check($sformatf("v%0d_addr_count", id), got_a.size(), exp_a.size());
        check($sformatf("v%0d_addr_seq", id), addr_err, 0);
        check($sformatf("v%0d_done_pulses", id), done_cnt, 1);
        check($sformatf("v%0d_busy_window", id), busy_err, 0);
        check($sformatf("v%0d_stall_stable", id), stab_err, 0);
        if (v.exp_n >= 0) check($sformatf("v%0d_table_count", id), got_q.size(), v.exp_n);
        if (v.exp_n > 0 && got_q.size() > 0)
            check($sformatf("v%0d_table_last_xy", id),
                  {got_q[got_q.size()-1].last, got_q[got_q.size()-1].x, got_q[got_q.size()-1].y},
                  {1'b1, 11'(v.exp_lx), 11'(v.exp_ly)});
        if (exp_q.size() == 0) begin
            check($sformatf("v%0d_zero_done_cycle", id), done_cyc, 1);
            check($sformatf("v%0d_zero_no_valid", id), n_valid, 0);
        end else if (v.mode == 0) begin
            check($sformatf("v%0d_first_rd_cycle", id), first_rd, 1);
            check($sformatf("v%0d_first_valid_cycle", id), first_valid, 3);
            check($sformatf("v%0d_valid_cycles", id), n_valid, exp_q.size());
            check($sformatf("v%0d_done_cycle", id), done_cyc, exp_q.size() + 4);
        end
    endtask

    initial begin
        vec_t rv;
        int   act;

        vecs[0] = '{8'h10, 4, 2, 100, 50, 0, 1'b0, 8, 103, 51};
        vecs[1] = '{8'h10, 4, 2, 100, 50, 2, 1'b0, 8, 103, 51};
        vecs[2] = '{8'h10, 4, 2, 100, 50, 1, 1'b0, 8, 103, 51};
        vecs[3] = '{8'hFE, 3, 1, 7, 9, 0, 1'b0, 3, 9, 9};
        vecs[4] = '{8'h00, 0, 5, 1, 1, 0, 1'b0, 0, 0, 0};
        vecs[5] = '{8'h20, 5, 0, 1, 1, 1, 1'b0, 0, 0, 0};
        vecs[6] = '{8'hF0, 7, 3, 2045, 2046, 1, 1'b0, 21, 3, 0};
        vecs[7] = '{8'h40, 4, 3, 10, 20, 0, 1'b1, 12, 13, 22};
        vecs[8] = '{8'h80, 1, 1, 5, 6, 2, 1'b0, 1, 5, 6};

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.spr_w     = '0;
        bus.spr_h     = '0;
        bus.org_x     = '0;
        bus.org_y     = '0;
        bus.pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {bus.busy, bus.done, bus.rom_rd, bus.rom_addr, bus.pix_valid,
                                bus.pix_last, bus.pix_x, bus.pix_y, bus.pix_data}, '0);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) run_case(i, vecs[i]);

        @(negedge clk);
        bus.base_addr = 8'h10;
        bus.spr_w     = 11'd4;
        bus.spr_h     = 11'd2;
        bus.org_x     = 11'd100;
        bus.org_y     = 11'd50;
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check("mid_reset_outputs", {bus.busy, bus.done, bus.rom_rd, bus.rom_addr, bus.pix_valid,
                                    bus.pix_last, bus.pix_x, bus.pix_y, bus.pix_data}, '0);
        rstn = 1'b1;
        act  = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.pix_valid || bus.rom_rd) act++;
        end
        check("mid_reset_quiet", act, 0);
        run_case(100, vecs[0]);

        for (int k = 0; k < 12; k++) begin
            rv.base   = 8'($urandom);
            rv.w      = $urandom_range(0, 6);
            rv.h      = $urandom_range(0, 5);
            rv.ox     = $urandom_range(0, 2047);
            rv.oy     = $urandom_range(0, 2047);
            rv.mode   = $urandom_range(0, 2);
            rv.mid    = (rv.w * rv.h >= 4) && ($urandom_range(0, 1) == 1);
            rv.exp_n  = -1;
            rv.exp_lx = 0;
            rv.exp_ly = 0;
            run_case(200 + k, rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
